// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_RDATA = 3'd6,
        S_WDATA = 3'd7
    } state_t;

    localparam int OP_W     = 2;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 16;
    localparam int BITCNT_W = 4;
    localparam int PRECNT_W = 6;

    localparam logic [OP_W-1:0] OP_READ  = 2'b10;
    localparam logic [OP_W-1:0] OP_WRITE = 2'b01;
    localparam logic [1:0]      TA_WRITE = 2'b10;

endpackage

// File: rtl/mdio_sync_edge.sv
// Synchronises MDC/MDIO into clk_i and flags MDC rising/falling edges.
// Latency: edge flags 2 clk_i cycles after the MDC transition; mdio_s_o aligned with them.
// Backpressure: none; free-running sampler.
//
// Ports: clk_i/rst_i (sync, active-high), mdc_i/mdio_i async inputs,
//        mdc_rise_o/mdc_fall_o single-cycle edge flags, mdio_s_o synchronised MDIO.
module mdio_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdc_rise_o,
    output logic mdc_fall_o,
    output logic mdio_s_o
);

    logic mdc_s1_q, mdc_s2_q, mdc_s3_q;
    logic mdio_s1_q, mdio_s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mdc_s1_q  <= 1'b0;
            mdc_s2_q  <= 1'b0;
            mdc_s3_q  <= 1'b0;
            mdio_s1_q <= 1'b0;
            mdio_s2_q <= 1'b0;
        end else begin
            mdc_s1_q  <= mdc_i;
            mdc_s2_q  <= mdc_s1_q;
            mdc_s3_q  <= mdc_s2_q;
            mdio_s1_q <= mdio_i;
            mdio_s2_q <= mdio_s1_q;
        end
    end

    // MDIO uses the same two-flop depth as MDC so the sampled bit lines up
    // with the edge flag that qualifies it.
    assign mdc_rise_o = mdc_s2_q & ~mdc_s3_q;
    assign mdc_fall_o = ~mdc_s2_q & mdc_s3_q;
    assign mdio_s_o   = mdio_s2_q;

endmodule

// File: rtl/mdio_responder.sv
// Clause 22 MDIO target: decodes frames to PHY_ADDR, strobes a register file, drives read data.
// Latency: register strobes ~3 clk_int after the MDC rise of the last field bit; MDIO drive changes ~3 clk_int after MDC fall.
// Backpressure: none; MDC-paced, reg_rdata must be valid the cycle after reg_rd_en.
//
// Ports: clk_int/rst_int (sync, active-high); mdc_i/mdio_i async management inputs;
//        mdio_o/mdio_oe tri-state drive; reg_addr/reg_rd_en/reg_rdata/reg_wr_en/reg_wdata
//        register-file interface; frame_err abort pulse; busy frame-in-progress flag.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_LEN  = 32
) (
    input  logic              clk_int,
    input  logic              rst_int,
    input  logic              mdc_i,
    input  logic              mdio_i,
    output logic              mdio_o,
    output logic              mdio_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_wr_en,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [PRECNT_W-1:0] PRE_MAX = PRECNT_W'(PRE_LEN);

    logic mdc_rise, mdc_fall, mdio_s;

    mdio_sync_edge u_sync (
        .clk_i      (clk_int),
        .rst_i      (rst_int),
        .mdc_i      (mdc_i),
        .mdio_i     (mdio_i),
        .mdc_rise_o (mdc_rise),
        .mdc_fall_o (mdc_fall),
        .mdio_s_o   (mdio_s)
    );

    state_t               state_q, state_d;
    logic [PRECNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [BITCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic                 is_read_q, is_read_d;
    logic                 rd_cap_q, rd_cap_d;
    logic                 mdio_o_q, mdio_o_d;
    logic                 mdio_oe_q, mdio_oe_d;
    logic [ADDR_W-1:0]    reg_addr_q, reg_addr_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    // Address fields are collected in the low bits of the data shifter.
    logic [OP_W-1:0]      op_bits;
    logic [ADDR_W-1:0]    addr_bits;
    assign op_bits   = {shift_q[0], mdio_s};
    assign addr_bits = {shift_q[ADDR_W-2:0], mdio_s};

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        is_read_d  = is_read_q;
        rd_cap_d   = rd_en_q;
        mdio_o_d   = mdio_o_q;
        mdio_oe_d  = mdio_oe_q;
        reg_addr_d = reg_addr_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        busy_d     = busy_q;

        // Read data arrives one cycle after the strobe; MDC edges are far
        // enough apart that this never coincides with a sampled bit.
        if (rd_cap_q) begin
            shift_d = reg_rdata;
        end

        if (mdc_rise) begin
            case (state_q)
                S_IDLE: begin
                    if (mdio_s) begin
                        if (pre_cnt_q != PRE_MAX) begin
                            pre_cnt_d = pre_cnt_q + 1'b1;
                        end
                    end else if (pre_cnt_q == PRE_MAX) begin
                        state_d   = S_ST;
                        busy_d    = 1'b1;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                S_ST: begin
                    if (mdio_s) begin
                        state_d   = S_OP;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                S_OP: begin
                    shift_d = {shift_q[DATA_W-2:0], mdio_s};
                    if (bit_cnt_q == 4'd1) begin
                        bit_cnt_d = '0;
                        if (op_bits == OP_READ || op_bits == OP_WRITE) begin
                            state_d   = S_PHYAD;
                            is_read_d = (op_bits == OP_READ);
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                S_PHYAD: begin
                    shift_d = {shift_q[DATA_W-2:0], mdio_s};
                    if (bit_cnt_q == 4'd4) begin
                        bit_cnt_d = '0;
                        // A frame for another PHY is simply dropped.
                        if (addr_bits == PHY_ADDR) begin
                            state_d = S_REGAD;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                S_REGAD: begin
                    shift_d = {shift_q[DATA_W-2:0], mdio_s};
                    if (bit_cnt_q == 4'd4) begin
                        reg_addr_d = addr_bits;
                        rd_en_d    = is_read_q;
                        state_d    = S_TA;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                S_TA: begin
                    if (is_read_q) begin
                        // Count TA rises; the drive happens on the following falls.
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (mdio_s != TA_WRITE[~bit_cnt_q[0]]) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else if (bit_cnt_q[0]) begin
                        state_d   = S_WDATA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = 4'd1;
                    end
                end
                S_WDATA: begin
                    shift_d = {shift_q[DATA_W-2:0], mdio_s};
                    if (bit_cnt_q == 4'd15) begin
                        wdata_d = {shift_q[DATA_W-2:0], mdio_s};
                        wr_en_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (mdc_fall) begin
            case (state_q)
                S_TA: begin
                    if (is_read_q && bit_cnt_q == 4'd1) begin
                        mdio_oe_d = 1'b1;
                        mdio_o_d  = 1'b0;
                    end else if (is_read_q && bit_cnt_q == 4'd2) begin
                        mdio_o_d  = shift_q[DATA_W-1];
                        state_d   = S_RDATA;
                        bit_cnt_d = 4'd15;
                    end
                end
                S_RDATA: begin
                    // bit_cnt holds the index of the bit currently on the line;
                    // once D0 has been sampled the line is released.
                    if (bit_cnt_q == '0) begin
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                        mdio_o_d  = shift_q[DATA_W-2];
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_int) begin
        if (rst_int) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            is_read_q  <= 1'b0;
            rd_cap_q   <= 1'b0;
            mdio_o_q   <= 1'b0;
            mdio_oe_q  <= 1'b0;
            reg_addr_q <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            is_read_q  <= is_read_d;
            rd_cap_q   <= rd_cap_d;
            mdio_o_q   <= mdio_o_d;
            mdio_oe_q  <= mdio_oe_d;
            reg_addr_q <= reg_addr_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_rd_en = rd_en_q;
    assign reg_wr_en = wr_en_q;
    assign reg_wdata = wdata_q;
    assign frame_err = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: table of whole frames plus preamble-break and mid-read reset sequences.
module tb_mdio_responder;

    logic        clk_int = 1'b0;
    logic        rst_int = 1'b1;
    logic        mdc_i   = 1'b0;
    logic        mdio_i;
    logic        mdio_o, mdio_oe;
    logic [4:0]  reg_addr;
    logic        reg_rd_en, reg_wr_en, frame_err, busy;
    logic [15:0] reg_rdata = 16'hDEAD;
    logic [15:0] reg_wdata;
    logic        drv_en  = 1'b1;
    logic        drv_val = 1'b1;

    always #4 clk_int = ~clk_int;

    // Shared line: initiator drives, else responder drives, else pull-up.
    assign mdio_i = drv_en ? drv_val : (mdio_oe ? mdio_o : 1'b1);

    mdio_responder #(.PHY_ADDR(5'd1), .PRE_LEN(32)) dut (
        .clk_int   (clk_int),
        .rst_int   (rst_int),
        .mdc_i     (mdc_i),
        .mdio_i    (mdio_i),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .reg_addr  (reg_addr),
        .reg_rd_en (reg_rd_en),
        .reg_rdata (reg_rdata),
        .reg_wr_en (reg_wr_en),
        .reg_wdata (reg_wdata),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rf_val(input logic [4:0] a);
        case (a)
            5'h02:   rf_val = 16'h0141;
            5'h03:   rf_val = 16'hA5C3;
            default: rf_val = 16'h0000;
        endcase
    endfunction

    // Monitor and register-file model; data is only valid the cycle after the strobe.
    int         wr_cnt, rd_cnt, err_cnt;
    logic       oe_seen, busy_seen, rd_prev = 1'b0;
    logic [4:0] wr_addr, rd_addr;
    logic [15:0] wr_data;

    always @(negedge clk_int) begin
        reg_rdata = rd_prev ? rf_val(rd_addr) : 16'hDEAD;
        rd_prev   = reg_rd_en;
        if (reg_rd_en) begin rd_cnt++; rd_addr = reg_addr; end
        if (reg_wr_en) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
        if (frame_err) err_cnt++;
        if (mdio_oe)   oe_seen = 1'b1;
        if (busy)      busy_seen = 1'b1;
    end

    logic [17:0] rx;
    int          oe_rises;

    // One MDC period: low half (line set up), sample at the rise, high half.
    task automatic bit_cycle(input logic en, input logic val);
        @(negedge clk_int);
        mdc_i = 1'b0; drv_en = en; drv_val = val;
        repeat (7) @(negedge clk_int);
        rx = {rx[16:0], mdio_i};
        if (mdio_oe) oe_rises++;
        mdc_i = 1'b1;
        repeat (8) @(negedge clk_int);
    endtask

    task automatic send_field(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_cycle(1'b1, bits[i]);
    endtask

    task automatic trail();
        @(negedge clk_int);
        mdc_i = 1'b0; drv_en = 1'b1; drv_val = 1'b1;
        repeat (8) @(negedge clk_int);
    endtask

    task automatic clear_mon();
        wr_cnt = 0; rd_cnt = 0; err_cnt = 0; oe_seen = 1'b0; busy_seen = 1'b0;
        rx = '0; oe_rises = 0;
    endtask

    typedef struct {
        int         pre;
        logic [1:0] st;
        logic [1:0] op;
        logic [4:0] phy;
        logic [4:0] ra;
        logic [1:0] ta;
        logic [15:0] wd;
        int         e_wr;
        int         e_rd;
        int         e_err;
        int         e_oe;
        logic       e_busy;
        logic [4:0] e_addr;
        logic [15:0] e_val;
    } vec_t;

    function automatic vec_t mk(input int pre, input logic [1:0] st, input logic [1:0] op,
                                input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                                input logic [15:0] wd, input int e_wr, input int e_rd, input int e_err,
                                input int e_oe, input logic e_busy, input logic [4:0] e_addr,
                                input logic [15:0] e_val);
        vec_t v;
        v.pre = pre; v.st = st; v.op = op; v.phy = phy; v.ra = ra; v.ta = ta; v.wd = wd;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_err = e_err; v.e_oe = e_oe; v.e_busy = e_busy;
        v.e_addr = e_addr; v.e_val = e_val;
        return v;
    endfunction

    // Leading 0 clears any preamble count left by earlier traffic.
    // abort_at >= 0 asserts reset after that released bit (0=TA1, 1=TA2, 2=D15 ...).
    task automatic run_frame(input vec_t v, input int abort_at);
        bit done = 1'b0;
        clear_mon();
        bit_cycle(1'b1, 1'b0);
        repeat (v.pre) bit_cycle(1'b1, 1'b1);
        send_field({14'd0, v.st}, 2);
        send_field({14'd0, v.op}, 2);
        send_field({11'd0, v.phy}, 5);
        send_field({11'd0, v.ra}, 5);
        if (v.op == 2'b10) begin
            for (int i = 0; i < 18; i++) begin
                if (!done) begin
                    bit_cycle(1'b0, 1'b1);
                    if (i == abort_at) begin
                        chk("rst_pre_oe", mdio_oe, 1'b1);
                        rst_int = 1'b1;
                        @(negedge clk_int);
                        chk("rst_same_edge_oe", mdio_oe, 1'b0);
                        chk("rst_same_edge_busy", busy, 1'b0);
                        rst_int = 1'b0;
                        done = 1'b1;
                    end
                end
            end
        end else begin
            send_field({14'd0, v.ta}, 2);
            send_field(v.wd, 16);
        end
        trail();
    endtask

    task automatic check_frame(input vec_t v, input int k);
        chk($sformatf("v%0d_wr_cnt", k), wr_cnt, v.e_wr);
        chk($sformatf("v%0d_rd_cnt", k), rd_cnt, v.e_rd);
        chk($sformatf("v%0d_err_cnt", k), err_cnt, v.e_err);
        chk($sformatf("v%0d_oe_rises", k), oe_rises, v.e_oe);
        chk($sformatf("v%0d_oe_seen", k), oe_seen, (v.e_oe != 0));
        chk($sformatf("v%0d_busy_seen", k), busy_seen, v.e_busy);
        chk($sformatf("v%0d_busy_end", k), busy, 1'b0);
        chk($sformatf("v%0d_oe_end", k), mdio_oe, 1'b0);
        if (v.e_wr != 0) begin
            chk($sformatf("v%0d_wr_addr", k), wr_addr, v.e_addr);
            chk($sformatf("v%0d_wr_data", k), wr_data, v.e_val);
        end
        if (v.e_rd != 0) begin
            chk($sformatf("v%0d_rd_addr", k), rd_addr, v.e_addr);
            chk($sformatf("v%0d_ta_line", k), rx[17:16], 2'b10);
        end
        if (v.op == 2'b10) chk($sformatf("v%0d_rd_line", k), rx[15:0], v.e_val);
    endtask

    localparam int NV = 12;
    vec_t vecs[NV];

    initial begin
        //             pre st     op     phy    ra     ta     wd        wr rd er oe busy  addr   val
        vecs[0]  = mk(32, 2'b01, 2'b01, 5'd1, 5'h04, 2'b10, 16'h01E1, 1, 0, 0, 0,  1'b1, 5'h04, 16'h01E1);
        vecs[1]  = mk(32, 2'b01, 2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 0, 1, 0, 17, 1'b1, 5'h02, 16'h0141);
        vecs[2]  = mk(32, 2'b01, 2'b10, 5'd3, 5'h02, 2'b00, 16'h0000, 0, 0, 0, 0,  1'b1, 5'h00, 16'hFFFF);
        vecs[3]  = mk(32, 2'b01, 2'b01, 5'd1, 5'h1F, 2'b10, 16'hA55A, 1, 0, 0, 0,  1'b1, 5'h1F, 16'hA55A);
        vecs[4]  = mk(31, 2'b01, 2'b01, 5'd1, 5'h04, 2'b10, 16'h1234, 0, 0, 0, 0,  1'b0, 5'h00, 16'h0000);
        vecs[5]  = mk(32, 2'b01, 2'b11, 5'd1, 5'h04, 2'b10, 16'h1234, 0, 0, 1, 0,  1'b1, 5'h00, 16'h0000);
        vecs[6]  = mk(32, 2'b01, 2'b01, 5'd1, 5'h04, 2'b11, 16'h1234, 0, 0, 1, 0,  1'b1, 5'h00, 16'h0000);
        vecs[7]  = mk(32, 2'b00, 2'b01, 5'd1, 5'h04, 2'b10, 16'h1234, 0, 0, 1, 0,  1'b1, 5'h00, 16'h0000);
        vecs[8]  = mk(32, 2'b01, 2'b10, 5'd1, 5'h03, 2'b00, 16'h0000, 0, 1, 0, 17, 1'b1, 5'h03, 16'hA5C3);
        vecs[9]  = mk(40, 2'b01, 2'b01, 5'd1, 5'h00, 2'b10, 16'hFFFF, 1, 0, 0, 0,  1'b1, 5'h00, 16'hFFFF);
        vecs[10] = mk(32, 2'b01, 2'b01, 5'd1, 5'h04, 2'b00, 16'h1234, 0, 0, 1, 0,  1'b1, 5'h00, 16'h0000);
        vecs[11] = mk(32, 2'b01, 2'b00, 5'd1, 5'h04, 2'b10, 16'h1234, 0, 0, 1, 0,  1'b1, 5'h00, 16'h0000);

        clear_mon();
        repeat (4) @(negedge clk_int);
        chk("rst_mdio_oe", mdio_oe, 1'b0);
        chk("rst_mdio_o", mdio_o, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {reg_rd_en, reg_wr_en, frame_err}, 3'b000);
        chk("rst_regs", {reg_addr, reg_wdata}, 21'd0);
        rst_int = 1'b0;
        repeat (4) @(negedge clk_int);

        for (int k = 0; k < NV; k++) begin
            run_frame(vecs[k], -1);
            check_frame(vecs[k], k);
        end

        // Preamble broken by a 0 at bit 20, then only 31 ones: must be ignored.
        clear_mon();
        bit_cycle(1'b1, 1'b0);
        repeat (19) bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b1, 1'b0);
        repeat (31) bit_cycle(1'b1, 1'b1);
        send_field(16'b01_01_00001_00100, 14);
        send_field(16'b10, 2);
        send_field(16'h1234, 16);
        trail();
        chk("prebreak_wr_cnt", wr_cnt, 0);
        chk("prebreak_busy_seen", busy_seen, 1'b0);

        // Reset while D7 is on the line, then a clean read must still work.
        run_frame(vecs[1], 10);
        chk("rst_abort_oe_after", mdio_oe, 1'b0);
        run_frame(vecs[1], -1);
        check_frame(vecs[1], 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
